// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/WB over a req/ack instruction port.
// Define PERF_CNT_EN to add the cycle_cnt_o / instret_cnt_o performance counters.
module multicycle_mips_core #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic            halt_o,
    output logic            dbg_we_o,
    output logic [4:0]      dbg_waddr_o,
    output logic [31:0]     dbg_wdata_o,
    output logic [PC_W-1:0] dbg_pc_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt_o,
    output logic [31:0]     instret_cnt_o
`endif
);

    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_BEQ
    } alu_e;

    state_e             state;
    logic [PC_W-1:0]    pc;
    logic [31:0]        ir;
    logic [31:0]        a_q, b_q, res_q;
    logic signed [31:0] br_off_q;
    logic [4:0]         shamt_q;
    alu_e               alu_q;
    logic [RW-1:0]      wr_idx_q;
    logic               wr_en_q, taken_q;
    logic [31:0]        rf [NUM_REGS];

    logic [5:0]    op, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]   imm_sext, rs_val, rt_val, dec_a, dec_b, alu_res;
    alu_e          dec_alu;
    logic          dec_legal, dec_wr, dec_use_rd;

    assign imem_addr_o = pc;
    assign dbg_pc_o    = pc;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        op         = ir[31:26];
        funct      = ir[5:0];
        rs_idx     = ir[21 +: RW];
        rt_idx     = ir[16 +: RW];
        rd_idx     = ir[11 +: RW];
        imm_sext   = {{16{ir[15]}}, ir[15:0]};
        rs_val     = (rs_idx == '0) ? '0 : rf[rs_idx];
        rt_val     = (rt_idx == '0) ? '0 : rf[rt_idx];
        dec_legal  = 1'b1;
        dec_wr     = 1'b1;
        dec_use_rd = 1'b0;
        dec_alu    = ALU_ADD;
        dec_a      = rs_val;
        dec_b      = imm_sext;
        case (op)
            6'h00: begin
                dec_use_rd = 1'b1;
                dec_b      = rt_val;
                case (funct)
                    6'h20: dec_alu = ALU_ADD;
                    6'h22: dec_alu = ALU_SUB;
                    6'h24: dec_alu = ALU_AND;
                    6'h25: dec_alu = ALU_OR;
                    6'h27: dec_alu = ALU_NOR;
                    6'h2A: dec_alu = ALU_SLT;
                    6'h00: begin dec_alu = ALU_SLL; dec_a = rt_val; end
                    6'h02: begin dec_alu = ALU_SRL; dec_a = rt_val; end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: dec_alu = ALU_ADD;
            6'h0D: begin dec_alu = ALU_OR; dec_b = {16'h0000, ir[15:0]}; end
            6'h0F: begin dec_a = '0; dec_b = {ir[15:0], 16'h0000}; end
            6'h04: begin dec_alu = ALU_BEQ; dec_b = rt_val; dec_wr = 1'b0; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (alu_q)
            ALU_ADD: alu_res = a_q + b_q;
            ALU_SUB: alu_res = a_q - b_q;
            ALU_AND: alu_res = a_q & b_q;
            ALU_OR:  alu_res = a_q | b_q;
            ALU_NOR: alu_res = ~(a_q | b_q);
            ALU_SLT: alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
            ALU_SLL: alu_res = a_q << shamt_q;
            ALU_SRL: alu_res = a_q >> shamt_q;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_off_q    <= '0;
            shamt_q     <= '0;
            alu_q       <= ALU_ADD;
            wr_idx_q    <= '0;
            wr_en_q     <= 1'b0;
            taken_q     <= 1'b0;
            imem_req_o  <= 1'b0;
            halt_o      <= 1'b0;
            dbg_we_o    <= 1'b0;
            dbg_waddr_o <= '0;
            dbg_wdata_o <= '0;
            // NOTE: the register file is architectural state that must read zero after reset, so it is reset here.
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            dbg_we_o <= 1'b0;
            case (state)
                S_FETCH: begin
                    // The cycle straight out of reset only raises req; later fetches enter with req already high.
                    if (!imem_req_o) begin
                        imem_req_o <= 1'b1;
                    end else if (imem_ack_i) begin
                        ir         <= imem_data_i;
                        imem_req_o <= 1'b0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        halt_o <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        a_q      <= dec_a;
                        b_q      <= dec_b;
                        alu_q    <= dec_alu;
                        shamt_q  <= ir[10:6];
                        br_off_q <= $signed(imm_sext << 2);
                        wr_idx_q <= dec_use_rd ? rd_idx : rt_idx;
                        wr_en_q  <= dec_wr;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q   <= alu_res;
                    taken_q <= (alu_q == ALU_BEQ) && (a_q == b_q);
                    state   <= S_WB;
                end
                S_WB: begin
                    if (wr_en_q && wr_idx_q != '0) begin
                        rf[wr_idx_q] <= res_q;
                        dbg_we_o     <= 1'b1;
                        dbg_waddr_o  <= 5'(wr_idx_q);
                        dbg_wdata_o  <= res_q;
                    end
                    pc         <= taken_q ? pc + PC_W'(4) + PC_W'(br_off_q) : pc + PC_W'(4);
                    imem_req_o <= 1'b1;
                    state      <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_o   <= '0;
            instret_cnt_o <= '0;
        end else begin
            if (state != S_HALT) cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (state == S_WB)   instret_cnt_o <= instret_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Scoreboard bench for multicycle_mips_core: an instruction-level reference model predicts
// fetch addresses and register writes; a memory responder and a write monitor check them.
module tb_multicycle_mips_core;

    localparam logic [31:0] RST_PC = 32'h40;
    localparam logic [31:0] NOP    = 32'h2000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        halt_o;
    logic        dbg_we_o;
    logic [4:0]  dbg_waddr_o;
    logic [31:0] dbg_wdata_o;
    logic [31:0] dbg_pc_o;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_o;
    logic [31:0] instret_cnt_o;
`endif

    multicycle_mips_core #(.PC_W(32), .RESET_PC(RST_PC), .NUM_REGS(32)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .halt_o      (halt_o),
        .dbg_we_o    (dbg_we_o),
        .dbg_waddr_o (dbg_waddr_o),
        .dbg_wdata_o (dbg_wdata_o),
        .dbg_pc_o    (dbg_pc_o)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o)
`endif
    );

    initial forever #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_fetch [$];
    logic [36:0] exp_wr [$];
    logic [36:0] obs_wr [$];
    int          we_cycles [$];
    bit          resp_en = 1'b0;
    int          ack_delay = 0;
    int          first_req_cyc, first_we_cyc, halt_cyc, last_ack_cyc;
    logic [31:0] last_ack_addr;
    bit          exp_halt;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : NOP;
    endfunction

    // Instruction-level reference: executes k instructions from RST_PC and queues expectations.
    task automatic iss_run(input int k);
        logic [31:0] r [32];
        logic [31:0] pc, ins, res, nxt, imm_s, imm_z;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [5:0]  op, fn;
        bit          wr;
        foreach (r[i]) r[i] = '0;
        pc = RST_PC;
        for (int n = 0; n < k; n++) begin
            exp_fetch.push_back(pc);
            ins   = mem_rd(pc);
            op    = ins[31:26];
            rs    = ins[25:21];
            rt    = ins[20:16];
            rd    = ins[15:11];
            sh    = ins[10:6];
            fn    = ins[5:0];
            imm_s = {{16{ins[15]}}, ins[15:0]};
            imm_z = {16'h0000, ins[15:0]};
            nxt   = pc + 32'd4;
            wr    = 1'b1;
            dst   = rt;
            res   = '0;
            if (op == 6'h00) begin
                dst = rd;
                case (fn)
                    6'h20: res = r[rs] + r[rt];
                    6'h22: res = r[rs] - r[rt];
                    6'h24: res = r[rs] & r[rt];
                    6'h25: res = r[rs] | r[rt];
                    6'h27: res = ~(r[rs] | r[rt]);
                    6'h2A: res = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
                    6'h00: res = r[rt] << sh;
                    6'h02: res = r[rt] >> sh;
                    default: begin exp_halt = 1'b1; return; end
                endcase
            end else begin
                case (op)
                    6'h08: res = r[rs] + imm_s;
                    6'h0D: res = r[rs] | imm_z;
                    6'h0F: res = imm_z << 16;
                    6'h04: begin
                        wr = 1'b0;
                        if (r[rs] == r[rt]) nxt = pc + 32'd4 + (imm_s << 2);
                    end
                    default: begin exp_halt = 1'b1; return; end
                endcase
            end
            if (wr && dst != 5'd0) begin
                r[dst] = res;
                exp_wr.push_back({dst, res});
            end
            pc = nxt;
        end
    endtask

    // Memory responder: serves only fetches the model expects, so the core stalls afterwards.
    initial begin
        int          wait_cnt  = 0;
        int          cur_delay = 0;
        logic [31:0] held_addr = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (!resp_en) begin
                wait_cnt = 0;
                continue;
            end
            imem_ack_i = 1'b0;
            if (!(imem_req_o && rst_n && exp_fetch.size() > 0)) begin
                wait_cnt = 0;
                continue;
            end
            if (wait_cnt == 0) begin
                cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                held_addr = imem_addr_o;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end else begin
                check("addr_stable_during_wait", imem_addr_o, held_addr);
            end
            if (wait_cnt == cur_delay) begin
                e = exp_fetch.pop_front();
                check("fetch_addr", imem_addr_o, e);
                check("dbg_pc", dbg_pc_o, e);
                imem_data_i   = mem_rd(imem_addr_o);
                imem_ack_i    = 1'b1;
                last_ack_cyc  = cyc;
                last_ack_addr = imem_addr_o;
                wait_cnt      = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Write monitor: every dbg_we_o pulse must match the next predicted register write.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_n && dbg_we_o) begin
                obs_wr.push_back({dbg_waddr_o, dbg_wdata_o});
                we_cycles.push_back(cyc);
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", dbg_we_o, 1'b0);
                end else begin
                    e = exp_wr.pop_front();
                    check("dbg_waddr", dbg_waddr_o, e[36:32]);
                    check("dbg_wdata", dbg_wdata_o, e[31:0]);
                end
            end
            if (rst_n && halt_o && halt_cyc < 0) halt_cyc = cyc;
        end
    end

    task automatic reset_start();
        @(negedge clk_i);
        #2;
        rst_n      = 1'b0;
        resp_en    = 1'b0;
        imem_ack_i = 1'b0;
        exp_fetch.delete();
        exp_wr.delete();
        obs_wr.delete();
        we_cycles.delete();
        first_req_cyc = -1;
        first_we_cyc  = -1;
        halt_cyc      = -1;
        last_ack_cyc  = -1;
        last_ack_addr = '0;
        exp_halt      = 1'b0;
        repeat (2) @(negedge clk_i);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_fetch.size() != 0 || exp_wr.size() != 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        repeat (6) @(negedge clk_i);
        check("fetch_queue_drained", 64'(exp_fetch.size()), 64'd0);
        check("write_queue_drained", 64'(exp_wr.size()), 64'd0);
    endtask

    task automatic run_program(input int k, input int delay, input int budget);
        reset_start();
        ack_delay = delay;
        iss_run(k);
        resp_en = 1'b1;
        rst_n   = 1'b1;
        wait_drain(budget);
        check("halt_matches_model", halt_o, exp_halt);
    endtask

    task automatic check_periods(input int p);
        for (int i = 1; i < we_cycles.size(); i++)
            check("instr_period", 64'(we_cycles[i] - we_cycles[i-1]), 64'(p));
    endtask

    task automatic load_basic();
        mem.delete();
        mem[32'h40] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[32'h44] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[32'h48] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        mem[32'h4C] = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A);
    endtask

    task automatic check_basic_writes();
        logic [36:0] want [4];
        want[0] = {5'd1, 32'd5};
        want[1] = {5'd2, 32'hFFFF_FFFD};
        want[2] = {5'd3, 32'd2};
        want[3] = {5'd4, 32'd1};
        check("basic_write_count", 64'(obs_wr.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_wr.size(); i++)
            check("basic_write_value", obs_wr[i], want[i]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  sh = 5'($urandom_range(0, 31));
        logic [15:0] imm = 16'($urandom);
        int          off = int'($urandom_range(0, 6)) - 3;
        case ($urandom_range(0, 11))
            0:  return enc_r(rs, rt, rd, 5'd0, 6'h20);
            1:  return enc_r(rs, rt, rd, 5'd0, 6'h22);
            2:  return enc_r(rs, rt, rd, 5'd0, 6'h24);
            3:  return enc_r(rs, rt, rd, 5'd0, 6'h25);
            4:  return enc_r(rs, rt, rd, 5'd0, 6'h27);
            5:  return enc_r(rs, rt, rd, 5'd0, 6'h2A);
            6:  return enc_r(5'd0, rt, rd, sh, 6'h00);
            7:  return enc_r(5'd0, rt, rd, sh, 6'h02);
            8:  return enc_i(6'h08, rs, rt, imm);
            9:  return enc_i(6'h0D, rs, rt, imm);
            10: return enc_i(6'h0F, 5'd0, rt, imm);
            default: return enc_i(6'h04, rs, rt, 16'(off));
        endcase
    endfunction

    initial begin
        int req_hi;

        // Reset state, then the basic program with immediate ack.
        load_basic();
        reset_start();
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_dbg_pc", dbg_pc_o, RST_PC);
        check("rst_halt", halt_o, 1'b0);
        check("rst_dbg_we", dbg_we_o, 1'b0);
        check("rst_dbg_waddr", dbg_waddr_o, 5'd0);
        check("rst_dbg_wdata", dbg_wdata_o, 32'd0);
`ifdef PERF_CNT_EN
        check("rst_instret", instret_cnt_o, 32'd0);
        check("rst_cycle_cnt", cycle_cnt_o, 32'd0);
`endif
        ack_delay = 0;
        iss_run(4);
        resp_en = 1'b1;
        rst_n   = 1'b1;
        wait_drain(100);
        check("first_write_latency", 64'(first_we_cyc - first_req_cyc), 64'd4);
        check_periods(4);
        check_basic_writes();
`ifdef PERF_CNT_EN
        check("instret_after_basic", instret_cnt_o, 32'd4);
`endif

        // Same program with every fetch acked three cycles late.
        run_program(4, 3, 200);
        check_periods(7);
        check_basic_writes();

        // Taken BEQ at 0x10.
        mem.delete();
        mem[32'h40] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[32'h44] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFF2);
        mem[32'h10] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        run_program(4, 0, 100);
        check("beq_taken_target", last_ack_addr, 32'h1C);
        check("beq_taken_writes", 64'(obs_wr.size()), 64'd1);

        // Not-taken BEQ at 0x10.
        mem[32'h10] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
        run_program(4, 0, 100);
        check("beq_not_taken_target", last_ack_addr, 32'h14);
        check("beq_not_taken_writes", 64'(obs_wr.size()), 64'd1);

        // Write to $0 followed by an illegal opcode.
        mem.delete();
        mem[32'h40] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        mem[32'h44] = 32'hFC00_0000;
        run_program(2, 0, 100);
        check("halt_after_decode", 64'(halt_cyc - last_ack_cyc), 64'd2);
        check("no_write_before_halt", 64'(obs_wr.size()), 64'd0);
        req_hi = 0;
`ifdef PERF_CNT_EN
        begin
            logic [31:0] frozen = cycle_cnt_o;
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (imem_req_o) req_hi++;
        end
        check("halt_req_low", 64'(req_hi), 64'd0);
        check("halt_held", halt_o, 1'b1);
`ifdef PERF_CNT_EN
            check("cycle_cnt_frozen_in_halt", cycle_cnt_o, frozen);
        end
`endif

        // Reset asserted mid-fetch, with a stale ack presented around the release.
        load_basic();
        reset_start();
        rst_n  = 1'b1;
        req_hi = 0;
        for (int i = 0; i < 10 && !imem_req_o; i++) @(negedge clk_i);
        check("req_after_release", imem_req_o, 1'b1);
        repeat (2) @(negedge clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        check("req_async_drop", imem_req_o, 1'b0);
        check("addr_after_async_rst", imem_addr_o, RST_PC);
        imem_data_i = enc_i(6'h08, 5'd0, 5'd5, 16'h1234);
        imem_ack_i  = 1'b1;
        @(negedge clk_i);
        #2;
        ack_delay = 0;
        iss_run(4);
        rst_n = 1'b1;
        @(posedge clk_i);
        #2;
        imem_ack_i = 1'b0;
        resp_en    = 1'b1;
        wait_drain(100);
        check_basic_writes();
`ifdef PERF_CNT_EN
        check("instret_after_rerun", instret_cnt_o, 32'd4);
`endif

        // Random programs with random ack latency.
        for (int p = 0; p < 6; p++) begin
            mem.delete();
            for (int i = 0; i < 30; i++) mem[RST_PC + 32'(4 * i)] = rand_instr();
            run_program(40, -1, 600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
